// File: rtl/alu_result_buf.sv
// alu_result_buf: DEPTH-entry result FIFO behind the 4-bit ALU, with push counter.
// Optional sticky {overflow,carry} flags enabled by defining ALU_RESULT_STICKY_EN.
module alu_result_buf #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 alu_fnselec,
    input  logic [DATA_W-1:0]          alu_res,
    input  logic                       alu_zero,
    input  logic                       alu_overflow,
    input  logic                       alu_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_fnselec,
    output logic [DATA_W-1:0]          out_res,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 push_cnt,
    input  logic                       sticky_clr,
    output logic [1:0]                 sticky_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_W + 6;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    push_cnt_q, push_cnt_d;
    logic          push, pop;
    logic [EW-1:0] head;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem_q[rd_ptr_q];

    // head fields are masked to zero while the FIFO is empty
    assign out_fnselec = out_valid ? head[EW-1 -: 3]     : '0;
    assign out_res     = out_valid ? head[3 +: DATA_W]  : '0;
    assign out_flags   = out_valid ? head[2:0]          : '0;
    assign count       = count_q;
    assign push_cnt    = push_cnt_q;

    // next state of storage, pointers, occupancy and push counter
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        push_cnt_d = push_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {alu_fnselec, alu_res,
                               alu_overflow, alu_carry, alu_zero};
            wr_ptr_d   = wr_ptr_q + AW'(1);
            push_cnt_d = push_cnt_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // state registers; reset drops any buffered entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            push_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            push_cnt_q <= push_cnt_d;
        end
    end

`ifdef ALU_RESULT_STICKY_EN
    logic [1:0] sticky_q, sticky_d;

    // clear first, then OR in the flags of an accepted push (set wins)
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) sticky_d = 2'b00;
        if (push) sticky_d = sticky_d | {alu_overflow, alu_carry};
    end

    // sticky flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 2'b00;
        else        sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_flags      = 2'b00;
`endif

endmodule
